// File: rtl/fpga_mem_dp_asym.sv
// True dual-port asymmetric-width buffer (port A narrow, port B = RATIO x wider) with byte enables,
// freeze lock and optional zero-clear after reset. Define FPGA_MEM_OUTREG_EN for a 2-cycle read latency.
module fpga_mem_dp_asym #(
  parameter  int A_DATA_W       = 128,
  parameter  int RATIO          = 2,
  parameter  int A_DEPTH        = 4096,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int B_DATA_W       = A_DATA_W * RATIO,
  localparam int B_DEPTH        = A_DEPTH / RATIO,
  localparam int A_ADDR_W       = $clog2(A_DEPTH),
  localparam int B_ADDR_W       = A_ADDR_W - $clog2(RATIO)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    freeze,
  output logic                    init_busy,
  input  logic [A_ADDR_W-1:0]     address,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic                    clken,
  input  logic [A_DATA_W/8-1:0]   byteenable,
  input  logic [A_DATA_W-1:0]     writedata,
  output logic [A_DATA_W-1:0]     readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  input  logic [B_ADDR_W-1:0]     address2,
  input  logic                    chipselect2,
  input  logic                    read2,
  input  logic                    write2,
  input  logic                    clken2,
  input  logic [B_DATA_W/8-1:0]   byteenable2,
  input  logic [B_DATA_W-1:0]     writedata2,
  output logic [B_DATA_W-1:0]     readdata2,
  output logic                    readdatavalid2,
  output logic                    waitrequest2
);

  localparam int LOG_R   = $clog2(RATIO);
  localparam int LANE_W  = (LOG_R > 0) ? LOG_R : 1;
  localparam int A_BYTES = A_DATA_W / 8;
  localparam int B_BYTES = B_DATA_W / 8;
  localparam logic [B_ADDR_W-1:0] LAST_PTR = B_ADDR_W'(B_DEPTH - 1);

  typedef enum logic [1:0] {INIT, CLEAR, READY} state_t;

  state_t              state_q, state_d;
  logic [B_ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [B_DATA_W-1:0] mem [B_DEPTH];

  logic [B_ADDR_W-1:0] a_word;
  logic [LANE_W-1:0]   a_lane;
  logic                ready, clear_we;
  logic                a_acc, a_we, a_re, b_acc, b_we, b_re, same_word;
  logic [B_DATA_W-1:0] a_old, b_old, a_new, b_new;
  logic [A_DATA_W-1:0] a_rword;

  logic [A_DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic                a_rvalid_q, a_rvalid_d;
  logic [B_DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic                b_rvalid_q, b_rvalid_d;

  assign a_word = address[A_ADDR_W-1:LOG_R];

  generate
    if (LOG_R > 0) begin : g_lane
      assign a_lane = address[LANE_W-1:0];
    end else begin : g_nolane
      assign a_lane = '0;
    end
  endgenerate

  // Reset blocks acceptance so nothing is written during the reset cycle itself.
  assign ready     = (state_q == READY) && !reset;
  assign clear_we  = (state_q == CLEAR);
  assign init_busy = (state_q == CLEAR) || (reset && (CLEAR_ON_RESET != 0));

  assign waitrequest  = !ready || !clken;
  assign waitrequest2 = !ready || !clken2;

  assign a_acc = ready && chipselect && (read || write) && clken;
  assign a_we  = a_acc && write && !freeze;
  assign a_re  = a_acc && read && !write;
  assign b_acc = ready && chipselect2 && (read2 || write2) && clken2;
  assign b_we  = b_acc && write2 && !freeze;
  assign b_re  = b_acc && read2 && !write2;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      INIT: begin
        clr_ptr_d = '0;
        state_d   = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      end
      CLEAR: begin
        if (clr_ptr_q == LAST_PTR) state_d = READY;
        else clr_ptr_d = clr_ptr_q + 1'b1;
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Both ports hitting one wide word are merged into a single value, A applied last so it wins overlaps.
  always_comb begin
    a_old     = mem[a_word];
    b_old     = mem[address2];
    same_word = a_we && b_we && (a_word == address2);
    b_new     = b_old;
    for (int i = 0; i < B_BYTES; i++) begin
      if (byteenable2[i]) b_new[i*8 +: 8] = writedata2[i*8 +: 8];
    end
    a_new = same_word ? b_new : a_old;
    for (int i = 0; i < A_BYTES; i++) begin
      if (byteenable[i]) a_new[(int'(a_lane)*A_BYTES + i)*8 +: 8] = writedata[i*8 +: 8];
    end
    if (same_word) b_new = a_new;
    a_rword = a_old[int'(a_lane)*A_DATA_W +: A_DATA_W];
  end

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clr_ptr_q] <= '0;
    end else begin
      if (b_we) mem[address2] <= b_new;
      if (a_we) mem[a_word]   <= a_new;
    end
  end

  always_comb begin
    a_rdata_d  = a_re ? a_rword : a_rdata_q;
    a_rvalid_d = a_re;
    b_rdata_d  = b_re ? b_old : b_rdata_q;
    b_rvalid_d = b_re;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rdata_q  <= '0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rdata_q  <= a_rdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rdata_q  <= b_rdata_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

`ifdef FPGA_MEM_OUTREG_EN
  logic [A_DATA_W-1:0] a_odata_q, a_odata_d;
  logic                a_ovalid_q, a_ovalid_d;
  logic [B_DATA_W-1:0] b_odata_q, b_odata_d;
  logic                b_ovalid_q, b_ovalid_d;

  always_comb begin
    a_odata_d  = a_rvalid_q ? a_rdata_q : a_odata_q;
    a_ovalid_d = a_rvalid_q;
    b_odata_d  = b_rvalid_q ? b_rdata_q : b_odata_q;
    b_ovalid_d = b_rvalid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_odata_q  <= '0;
      a_ovalid_q <= 1'b0;
      b_odata_q  <= '0;
      b_ovalid_q <= 1'b0;
    end else begin
      a_odata_q  <= a_odata_d;
      a_ovalid_q <= a_ovalid_d;
      b_odata_q  <= b_odata_d;
      b_ovalid_q <= b_ovalid_d;
    end
  end

  assign readdata       = a_odata_q;
  assign readdatavalid  = a_ovalid_q;
  assign readdata2      = b_odata_q;
  assign readdatavalid2 = b_ovalid_q;
`else
  assign readdata       = a_rdata_q;
  assign readdatavalid  = a_rvalid_q;
  assign readdata2      = b_rdata_q;
  assign readdatavalid2 = b_rvalid_q;
`endif

endmodule

// File: tb/tb_fpga_mem_dp_asym.sv
// Directed bench for fpga_mem_dp_asym at default parameters; adapts read latency to FPGA_MEM_OUTREG_EN.
module tb_fpga_mem_dp_asym;

`ifdef FPGA_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         reset, freeze, init_busy;
  logic [11:0]  address;
  logic         chipselect, read, write, clken;
  logic [15:0]  byteenable;
  logic [127:0] writedata, readdata;
  logic         readdatavalid, waitrequest;
  logic [10:0]  address2;
  logic         chipselect2, read2, write2, clken2;
  logic [31:0]  byteenable2;
  logic [255:0] writedata2, readdata2;
  logic         readdatavalid2, waitrequest2;

  int checks = 0;
  int errors = 0;

  fpga_mem_dp_asym dut (
    .clk(clk), .reset(reset), .freeze(freeze), .init_busy(init_busy),
    .address(address), .chipselect(chipselect), .read(read), .write(write), .clken(clken),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .address2(address2), .chipselect2(chipselect2), .read2(read2), .write2(write2), .clken2(clken2),
    .byteenable2(byteenable2), .writedata2(writedata2), .readdata2(readdata2),
    .readdatavalid2(readdatavalid2), .waitrequest2(waitrequest2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic a_rd, input logic a_wr, input logic [11:0] a_addr,
                               input logic [15:0] a_be, input logic [127:0] a_wd,
                               input logic b_rd, input logic b_wr, input logic [10:0] b_addr,
                               input logic [31:0] b_be, input logic [255:0] b_wd);
    chipselect  = a_rd | a_wr;
    read        = a_rd;
    write       = a_wr;
    address     = a_addr;
    byteenable  = a_be;
    writedata   = a_wd;
    chipselect2 = b_rd | b_wr;
    read2       = b_rd;
    write2      = b_wr;
    address2    = b_addr;
    byteenable2 = b_be;
    writedata2  = b_wd;
  endtask

  task automatic idleBus();
    applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  // One-cycle request already applied; checks the valid pulse lands exactly LAT cycles later.
  task automatic expectRead(input bit portb, input logic [255:0] exp, input string tag);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 1) idleBus();
      if (portb) begin
        checkOutput({tag, "_valid"}, 256'(readdatavalid2), 256'(k == LAT));
        if (k == LAT) checkOutput(tag, readdata2, exp);
      end else begin
        checkOutput({tag, "_valid"}, 256'(readdatavalid), 256'(k == LAT));
        if (k == LAT) checkOutput(tag, 256'(readdata), exp);
      end
    end
  endtask

  task automatic readA(input logic [11:0] a, input logic [127:0] exp, input string tag);
    applyStimulus(1, 0, a, '0, '0, 0, 0, '0, '0, '0);
    expectRead(0, 256'(exp), tag);
  endtask

  task automatic readB(input logic [10:0] a, input logic [255:0] exp, input string tag);
    applyStimulus(0, 0, '0, '0, '0, 1, 0, a, '0, '0);
    expectRead(1, exp, tag);
  endtask

  task automatic waitForClear(input string tag);
    int busy_cnt = 0;
    int wr_bad   = 0;
    bit done     = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (init_busy === 1'b1) begin
        busy_cnt++;
        if (waitrequest !== 1'b1 || waitrequest2 !== 1'b1) wr_bad++;
      end else if (waitrequest === 1'b0) begin
        done = 1;
      end
    end
    checkOutput({tag, "_ready"}, 256'(done), 256'(1));
    checkOutput({tag, "_busy_cycles"}, 256'(busy_cnt), 256'(2048));
    checkOutput({tag, "_waitreq_low_while_busy"}, 256'(wr_bad), 256'(0));
  endtask

  initial begin
    reset  = 1'b1;
    freeze = 1'b0;
    clken  = 1'b1;
    clken2 = 1'b1;
    idleBus();
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_init_busy", 256'(init_busy), 256'(1));
    checkOutput("rst_waitreq", 256'(waitrequest), 256'(1));
    checkOutput("rst_waitreq2", 256'(waitrequest2), 256'(1));
    checkOutput("rst_readdata", 256'(readdata), 256'(0));
    checkOutput("rst_rdv", 256'(readdatavalid), 256'(0));
    checkOutput("rst_readdata2", readdata2, 256'(0));
    checkOutput("rst_rdv2", 256'(readdatavalid2), 256'(0));
    reset = 1'b0;
    waitForClear("clear1");

    readA(12'd4095, '0, "rd_a4095_cleared");

    $display("[TB] lane mapping");
    applyStimulus(0, 1, 12'd6, 16'hFFFF, {16{8'h11}}, 0, 0, '0, '0, '0);
    @(negedge clk);
    applyStimulus(0, 1, 12'd7, 16'hFFFF, {16{8'h22}}, 0, 0, '0, '0, '0);
    @(negedge clk);
    readB(11'd3, {{16{8'h22}}, {16{8'h11}}}, "rd_b3_lanes");

    applyStimulus(0, 0, '0, '0, '0, 0, 1, 11'd0, 32'h0000_000F, {32{8'hFF}});
    @(negedge clk);
    readA(12'd0, 128'hFFFF_FFFF, "rd_a0_byteen");

    $display("[TB] write collisions");
    applyStimulus(0, 1, 12'd0, 16'hFFFF, {16{8'hAA}}, 0, 1, 11'd0, 32'hFFFF_FFFF, {32{8'h55}});
    @(negedge clk);
    readB(11'd0, {{16{8'h55}}, {16{8'hAA}}}, "rd_b0_full_collision");

    applyStimulus(0, 1, 12'd1, 16'h00FF, {16{8'hCC}}, 0, 1, 11'd0, 32'hFFFF_FFFF, {32{8'h77}});
    @(negedge clk);
    readB(11'd0, {{8{8'h77}}, {8{8'hCC}}, {16{8'h77}}}, "rd_b0_partial_collision");

    applyStimulus(0, 1, 12'd0, 16'hFFFF, {16{8'h33}}, 1, 0, 11'd0, '0, '0);
    expectRead(1, {{8{8'h77}}, {8{8'hCC}}, {16{8'h77}}}, "rdw_old_data");
    readA(12'd0, {16{8'h33}}, "rd_a0_after_rdw");

    applyStimulus(0, 1, 12'd2, 16'hFFFF, {16{8'h02}}, 0, 1, 11'd1, 32'hFFFF_0000,
                  {{16{8'h03}}, {16{8'hEE}}});
    @(negedge clk);
    readB(11'd1, {{16{8'h03}}, {16{8'h02}}}, "rd_b1_merged_lanes");

    $display("[TB] back-to-back reads");
    for (int k = 1; k <= LAT + 3; k++) begin
      if (k == 1) applyStimulus(1, 0, 12'd1, '0, '0, 0, 0, '0, '0, '0);
      @(negedge clk);
      if (k == 1) address = 12'd2;
      else if (k == 2) address = 12'd3;
      else if (k == 3) idleBus();
      checkOutput($sformatf("b2b_valid_%0d", k), 256'(readdatavalid),
                  256'(k >= LAT && k <= LAT + 2));
      if (k == LAT)     checkOutput("b2b_data_a1", 256'(readdata), 256'({{8{8'h77}}, {8{8'hCC}}}));
      if (k == LAT + 1) checkOutput("b2b_data_a2", 256'(readdata), 256'({16{8'h02}}));
      if (k == LAT + 2) checkOutput("b2b_data_a3", 256'(readdata), 256'({16{8'h03}}));
    end
    @(negedge clk);
    checkOutput("hold_readdata", 256'(readdata), 256'({16{8'h03}}));

    $display("[TB] freeze and request variants");
    freeze = 1'b1;
    applyStimulus(0, 1, 12'd10, 16'hFFFF, 128'd1, 0, 0, '0, '0, '0);
    #1;
    checkOutput("freeze_no_stall", 256'(waitrequest), 256'(0));
    @(negedge clk);
    idleBus();
    freeze = 1'b0;
    readA(12'd10, '0, "rd_a10_frozen");

    applyStimulus(1, 1, 12'd20, 16'hFFFF, 128'd5, 0, 0, '0, '0, '0);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      idleBus();
      checkOutput("rw_both_no_valid", 256'(readdatavalid), 256'(0));
    end
    readA(12'd20, 128'd5, "rd_a20_written");

    clken = 1'b0;
    applyStimulus(1, 0, 12'd20, '0, '0, 0, 0, '0, '0, '0);
    #1;
    checkOutput("clken_low_waitreq", 256'(waitrequest), 256'(1));
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      checkOutput("clken_low_no_valid", 256'(readdatavalid), 256'(0));
    end
    idleBus();
    clken = 1'b1;

    $display("[TB] reset during clear");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (500) @(negedge clk);
    checkOutput("mid_clear_busy", 256'(init_busy), 256'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    waitForClear("clear2");
    readA(12'd6, '0, "rd_a6_recleared");
    readB(11'd1, '0, "rd_b1_recleared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
